// File: rtl/restore_debounce.sv
// Restore-button debouncer: two-flop synchronizer, press/release debounce FSM,
// single-cycle restore pulse and a wrapping press counter.
module restore_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        ACTIVE_LEVEL    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_raw,
    output logic       restore,
    output logic       button_state,
    output logic [7:0] press_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE          = 2'd0;
    localparam logic [1:0] CHECK_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED       = 2'd2;
    localparam logic [1:0] CHECK_RELEASE = 2'd3;

    logic             sync1;
    logic             sync2;
    logic             btn_s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;

    // Synchronizer idles at the not-pressed level so reset never looks like a press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= ~ACTIVE_LEVEL;
            sync2 <= ~ACTIVE_LEVEL;
        end else begin
            sync1 <= button_raw;
            sync2 <= sync1;
        end
    end

    assign btn_s = ~(sync2 ^ ACTIVE_LEVEL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: any contrary sample restarts the debounce window
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = CHECK_PRESS;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            CHECK_PRESS: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = CHECK_RELEASE;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHECK_RELEASE: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs registered from next-state so they rise on the accepting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            restore      <= 1'b0;
            button_state <= 1'b0;
            press_count  <= '0;
        end else begin
            restore      <= pulse_nxt;
            button_state <= (state_nxt == PRESSED) || (state_nxt == CHECK_RELEASE);
            if (pulse_nxt) begin
                press_count <= press_count + 8'(1);
            end
        end
    end

endmodule

// File: tb/tb_restore_debounce.sv
// Scoreboard bench: pulses expected at stimulus time, checked when restore fires,
// on an active-high and an active-low instance driven with mirrored inputs.
module tb_restore_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       raw;
    logic       raw0;
    logic       restore1, button_state1;
    logic       restore0, button_state0;
    logic [7:0] press_count1, press_count0;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q1[$];
    exp_t       q0[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    assign raw0 = ~raw;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    restore_debounce #(.DEBOUNCE_CYCLES(4), .ACTIVE_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .button_raw(raw),
        .restore(restore1), .button_state(button_state1), .press_count(press_count1)
    );

    restore_debounce #(.DEBOUNCE_CYCLES(4), .ACTIVE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .button_raw(raw0),
        .restore(restore0), .button_state(button_state0), .press_count(press_count0)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int rs, input int bs, input int pc);
        check({tag, "_restore1"}, int'(restore1), rs);
        check({tag, "_state1"}, int'(button_state1), bs);
        check({tag, "_count1"}, int'(press_count1), pc);
        check({tag, "_restore0"}, int'(restore0), rs);
        check({tag, "_state0"}, int'(button_state0), bs);
        check({tag, "_count0"}, int'(press_count0), pc);
    endtask

    // Raw driven at this negedge is first sampled one edge later; pulse lands 5 edges after that
    task automatic expect_pulse();
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.cyc = cyc + 6;
        e.cnt = exp_cnt;
        q1.push_back(e);
        q0.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard consumer: every restore pulse must match a queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (restore1) begin
            if (q1.size() == 0) begin
                check("al1_spurious_pulse", int'(restore1), 0);
            end else begin
                e = q1.pop_front();
                check("al1_pulse_cycle", cyc, e.cyc);
                check("al1_pulse_count", int'(press_count1), int'(e.cnt));
                check("al1_pulse_state", int'(button_state1), 1);
            end
        end
        if (restore0) begin
            if (q0.size() == 0) begin
                check("al0_spurious_pulse", int'(restore0), 0);
            end else begin
                e = q0.pop_front();
                check("al0_pulse_cycle", cyc, e.cyc);
                check("al0_pulse_count", int'(press_count0), int'(e.cnt));
                check("al0_pulse_state", int'(button_state0), 1);
            end
        end
    end

    initial begin
        int bounce[5];
        bounce = '{1, 0, 1, 1, 0};
        raw     = 1'b0;
        reset_n = 1'b0;

        // Reset state
        wait_neg(3);
        check_outs("reset", 0, 0, 0);
        reset_n = 1'b1;
        wait_neg(4);
        check_outs("idle", 0, 0, 0);

        // Clean press held 20 cycles, then release
        expect_pulse();
        raw = 1'b1;
        wait_neg(5);
        check_outs("pre_accept", 0, 0, 0);
        wait_neg(15);
        check_outs("held", 0, 1, 1);
        raw = 1'b0;
        wait_neg(10);
        check_outs("released", 0, 0, 1);
        check("clean_drained", q1.size() + q0.size(), 0);

        // Bounce then steady press
        for (int i = 0; i < 5; i++) begin
            raw = bounce[i][0];
            @(negedge clk);
            check("bounce_state1", int'(button_state1), 0);
        end
        expect_pulse();
        raw = 1'b1;
        wait_neg(10);
        check_outs("bounce_held", 0, 1, 2);
        raw = 1'b0;
        wait_neg(10);
        check("bounce_drained", q1.size() + q0.size(), 0);

        // Release glitch shorter than the window, then a real release
        expect_pulse();
        raw = 1'b1;
        wait_neg(10);
        raw = 1'b0;
        wait_neg(2);
        raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("glitch_state1", int'(button_state1), 1);
            check("glitch_state0", int'(button_state0), 1);
        end
        raw = 1'b0;
        wait_neg(5);
        check_outs("release_last", 0, 1, 3);
        wait_neg(1);
        check_outs("release_done", 0, 0, 3);
        wait_neg(6);
        check("glitch_drained", q1.size() + q0.size(), 0);

        // Reset in CHECK_PRESS with cnt=2 while held; fresh debounce afterwards
        raw = 1'b1;
        wait_neg(4);
        reset_n = 1'b0;
        #1;
        check_outs("midreset_now", 0, 0, 0);
        wait_neg(2);
        check_outs("midreset_hold", 0, 0, 0);
        exp_cnt = 8'd0;
        reset_n = 1'b1;
        expect_pulse();
        wait_neg(12);
        check_outs("post_reset", 0, 1, 1);
        raw = 1'b0;
        wait_neg(10);
        check("reset_drained", q1.size() + q0.size(), 0);

        // 256 clean presses from zero wrap the counter
        reset_n = 1'b0;
        wait_neg(1);
        reset_n = 1'b1;
        exp_cnt = 8'd0;
        wait_neg(3);
        for (int i = 0; i < 256; i++) begin
            expect_pulse();
            raw = 1'b1;
            wait_neg(6);
            raw = 1'b0;
            wait_neg(8);
        end
        check_outs("wrap", 0, 0, 0);
        check("wrap_drained", q1.size() + q0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/restore_debounce.md
RESTORE_DEBOUNCE -- requirements
Module: restore_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples needed to accept a press or a release; legal range 2..65535.
REQ-002 SHALL have parameter ACTIVE_LEVEL, default 1: raw button level that means "pressed".
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port button_raw  input  1  raw, asynchronous, bouncing restore button.
REQ-006 SHALL have port restore  output  1  single-cycle, registered pulse per accepted press; feeds the restore latch stage.
REQ-007 SHALL have port button_state  output  1  debounced level, 1 = pressed.
REQ-008 SHALL have port press_count  output  8  number of accepted presses, modulo 256.
REQ-009 One clock. Reset is asynchronous and active-low.

Function
REQ-010 SHALL pass button_raw through a two-flop synchronizer; btn_s is the second flop XNOR ACTIVE_LEVEL (1 = pressed); no logic reads button_raw directly.
REQ-011 SHALL implement FSM states IDLE, CHECK_PRESS, PRESSED, CHECK_RELEASE with a sample counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
REQ-012 IDLE: btn_s=1 -> CHECK_PRESS, cnt=1; else stay, cnt=0.
REQ-013 CHECK_PRESS: btn_s=0 -> IDLE, cnt=0 (any glitch restarts debounce); btn_s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0.
REQ-014 PRESSED: btn_s=0 -> CHECK_RELEASE, cnt=1; else stay.
REQ-015 CHECK_RELEASE: btn_s=1 -> PRESSED, cnt=0, no new pulse; btn_s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, cnt=0; otherwise cnt+1.
REQ-016 restore SHALL be 1 for exactly the one cycle following the CHECK_PRESS->PRESSED edge, and 0 at all other times.
REQ-017 Latency: if button_raw is first sampled pressed at edge k and stays pressed, restore SHALL be high from edge k+DEBOUNCE_CYCLES+1 to edge k+DEBOUNCE_CYCLES+2.
REQ-018 button_state SHALL be 1 in PRESSED and CHECK_RELEASE, 0 in IDLE and CHECK_PRESS; it is registered and rises on the same edge as restore.
REQ-019 press_count SHALL increment on the same edge restore rises; 255 wraps to 0.
REQ-020 A held button SHALL produce exactly one pulse; a new pulse requires a full debounced release (return to IDLE) first.
REQ-021 Bounces shorter than DEBOUNCE_CYCLES samples in either direction SHALL NOT change button_state or emit restore.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-023 reset_n=0 SHALL immediately force state=IDLE, cnt=0, restore=0, button_state=0, press_count=0, and both synchronizer flops to the not-pressed level (~ACTIVE_LEVEL).
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL abort with no pulse emitted after release of reset; a still-held button SHALL then be debounced afresh from IDLE.
REQ-025 Reset is released synchronously to clk by the system; the block SHALL need no internal reset-release synchronizer.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LEVEL=1)
REQ-026 Clean press: raw 0->1 sampled at edge 10, held 20 cycles -> restore high for exactly edge 15 to 16; button_state=1 from edge 15; press_count=1; no second pulse while held.
REQ-027 Bounce: raw toggles 1,0,1,1,0 on successive edges, then steady 1 -> no pulse during the bounce; exactly one pulse 5 edges after the start of the steady run.
REQ-028 Release glitch: from PRESSED, raw low for 2 cycles then high -> button_state stays 1, no pulse; then low for 10 cycles -> button_state drops to 0 via CHECK_RELEASE.
REQ-029 Wrap: 256 clean press/release cycles -> 256 pulses; press_count reads 0 after the last one.
REQ-030 Mid-operation reset: reset_n pulsed low in CHECK_PRESS with cnt=2 while raw is held at 1 -> all outputs 0 during reset; after release, one pulse at 4+1 edges after the first post-reset sample.
REQ-031 ACTIVE_LEVEL=0 instance: raw idles at 1, press drives it to 0 -> same timing as REQ-026.
